// File: rtl/router_out_ctrl.sv
// Read-side controller for one 1x3 router output FIFO: frames packets, streams them on
// valid/ready, flushes the FIFO on destination stall. Optional parity check: PARITY_CHECK_EN.
module router_out_ctrl #(
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned TO_W    = 5
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_read_enb,
    output logic       soft_reset,
    input  logic       dst_ready,
    output logic       vld_out,
    output logic [7:0] data_out,
    output logic       sop,
    output logic       eop,
    output logic       parity_err
);

    typedef enum logic [2:0] {StIdle, StHdr, StBody, StDrain, StFlush} state_e;

    state_e          state_q, state_d;
    logic [1:0]      occ_q, occ_d;
    logic            inflight_q, inflight_d;
    logic [6:0]      req_left_q, req_left_d;
    logic [TO_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            soft_reset_q, soft_reset_d;
    // Skid entries: {eop, sop, data}; entry 0 is the head.
    logic [9:0]      ent0_q, ent0_d, ent1_q, ent1_d;

    logic       beat, stall, timeout, rd, push;
    logic [9:0] push_ent;
    logic [1:0] occ_mid;
    logic [2:0] fill;

    assign vld_out       = (occ_q != 2'd0);
    assign data_out      = ent0_q[7:0];
    assign sop           = vld_out & ent0_q[8];
    assign eop           = vld_out & ent0_q[9];
    assign soft_reset    = soft_reset_q;
    assign fifo_read_enb = rd;

    assign beat    = vld_out & dst_ready;
    assign stall   = vld_out & ~dst_ready;
    assign timeout = stall && (stall_cnt_q == TO_W'(TIMEOUT - 1));
    assign occ_mid = occ_q - {1'b0, beat};
    assign fill    = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, beat};

    always_comb begin
        state_d      = state_q;
        req_left_d   = req_left_q;
        rd           = 1'b0;
        push         = 1'b0;
        push_ent     = {2'b00, fifo_data};
        soft_reset_d = timeout;
        stall_cnt_d  = stall ? stall_cnt_q + TO_W'(1) : '0;

        unique case (state_q)
            StIdle: begin
                rd = ~fifo_empty;
                if (rd) state_d = StHdr;
            end
            StHdr: begin
                push       = inflight_q;
                push_ent   = {2'b01, fifo_data};
                req_left_d = 7'(fifo_data[7:2]) + 7'd1;
                state_d    = StBody;
            end
            StBody: begin
                rd = ~fifo_empty && (req_left_q != 7'd0) && (fill < 3'd2);
                if (inflight_q) begin
                    push     = 1'b1;
                    push_ent = {(req_left_q == 7'd0), 1'b0, fifo_data};
                end
                if (rd) req_left_d = req_left_q - 7'd1;
                if ((req_left_q == 7'd0) && !inflight_q) state_d = StDrain;
            end
            StDrain: begin
                if (occ_q == 2'd0) state_d = StIdle;
            end
            StFlush: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // No new reads while the FIFO is about to be flushed or held in reset.
        rd = rd & ~timeout & resetn;

        ent0_d = beat ? ent1_q : ent0_q;
        ent1_d = ent1_q;
        if (push) begin
            if (occ_mid == 2'd0) ent0_d = push_ent;
            else                 ent1_d = push_ent;
        end
        occ_d      = occ_mid + {1'b0, push};
        inflight_d = rd;

        if (timeout) begin
            state_d     = StFlush;
            occ_d       = 2'd0;
            inflight_d  = 1'b0;
            stall_cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= StIdle;
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            req_left_q   <= 7'd0;
            stall_cnt_q  <= '0;
            soft_reset_q <= 1'b0;
            ent0_q       <= 10'd0;
            ent1_q       <= 10'd0;
        end else begin
            state_q      <= state_d;
            occ_q        <= occ_d;
            inflight_q   <= inflight_d;
            req_left_q   <= req_left_d;
            stall_cnt_q  <= stall_cnt_d;
            soft_reset_q <= soft_reset_d;
            ent0_q       <= ent0_d;
            ent1_q       <= ent1_d;
        end
    end

`ifdef PARITY_CHECK_EN
    logic [7:0] acc_q, acc_d;
    logic       perr_q, perr_d;

    // Accumulator seeded by the header; the byte arriving with no reads left is parity.
    always_comb begin
        acc_d  = acc_q;
        perr_d = perr_q;
        if (inflight_q && (state_q == StHdr)) begin
            acc_d  = fifo_data;
            perr_d = 1'b0;
        end else if (inflight_q && (state_q == StBody)) begin
            if (req_left_q == 7'd0) perr_d = (acc_q != fifo_data);
            else                    acc_d  = acc_q ^ fifo_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            acc_q  <= 8'd0;
            perr_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_out_ctrl.sv
// Scoreboard bench for router_out_ctrl: a FIFO model feeds packets, a monitor checks every
// beat against the expected queue, directed tests cover framing, parity, timeout and reset.
module tb_router_out_ctrl;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'hEE;
    logic       dst_ready = 1'b0;
    logic       fifo_read_enb, soft_reset, vld_out, sop, eop, parity_err;
    logic [7:0] data_out;

    router_out_ctrl dut (
        .clock         (clock),
        .resetn        (resetn),
        .fifo_empty    (fifo_empty),
        .fifo_data     (fifo_data),
        .fifo_read_enb (fifo_read_enb),
        .soft_reset    (soft_reset),
        .dst_ready     (dst_ready),
        .vld_out       (vld_out),
        .data_out      (data_out),
        .sop           (sop),
        .eop           (eop),
        .parity_err    (parity_err)
    );

    always #5 clock = ~clock;

`ifdef PARITY_CHECK_EN
    localparam logic PerrExp = 1'b1;
`else
    localparam logic PerrExp = 1'b0;
`endif

    logic [7:0] fifo_q[$];
    logic [9:0] exp_q[$];
    int tests = 0, fails = 0;
    int cyc = 0, beat_cnt = 0, dst_mode = 0, rd_viol = 0;
    int sr_cycles = 0, sr_stall = 0, stall_run = 0, sr_vld_bad = 0;
    int beat_time[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every beat, checks hold during stalls.
    initial begin
        logic       prev_stall;
        logic [9:0] prev_out, e;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clock);
            if (soft_reset) begin
                sr_cycles++;
                sr_stall = stall_run;
                if (vld_out) sr_vld_bad++;
            end
            if (prev_stall && vld_out)
                check("hold", {22'd0, eop, sop, data_out}, {22'd0, prev_out});
            if (vld_out && !dst_ready) stall_run++;
            else                       stall_run = 0;
            if (vld_out && dst_ready) begin
                beat_cnt++;
                beat_time.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got %0h expected none", {eop, sop, data_out});
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {22'd0, eop, sop, data_out}, {22'd0, e});
                end
            end
            prev_stall = vld_out & ~dst_ready;
            prev_out   = {eop, sop, data_out};
        end
    end

    // FIFO model and destination ready driver.
    initial begin
        logic rd, sr;
        forever begin
            @(negedge clock);
            rd = fifo_read_enb;
            sr = soft_reset;
            if (rd && fifo_empty) rd_viol++;
            @(posedge clock);
            #1;
            if (rd && fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
            else                         fifo_data = 8'hEE;
            if (sr) fifo_q.delete();
            fifo_empty = (fifo_q.size() == 0);
            case (dst_mode)
                0:       dst_ready = 1'b1;
                1:       dst_ready = 1'($urandom_range(0, 1));
                default: dst_ready = 1'b0;
            endcase
        end
    end

    task automatic send_pkt(input logic [5:0] len, input logic [1:0] addr,
                            input logic [7:0] base, input bit bad);
        logic [7:0] hdr, par, b;
        hdr = {len, addr};
        par = hdr;
        fifo_q.push_back(hdr);
        exp_q.push_back({2'b01, hdr});
        for (int i = 0; i < int'(len); i++) begin
            b = base + 8'(i * 17);
            par ^= b;
            fifo_q.push_back(b);
            exp_q.push_back({2'b00, b});
        end
        if (bad) par ^= 8'h03;
        fifo_q.push_back(par);
        exp_q.push_back({2'b10, par});
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clock);
            n++;
        end
        check(name, exp_q.size(), 0);
        repeat (4) @(posedge clock);
    endtask

    task automatic wait_beats(input int target);
        int n;
        n = 0;
        while (beat_cnt < target && n < 100) begin
            @(posedge clock);
            n++;
        end
        check("beat_wait", 32'(beat_cnt >= target), 1);
    endtask

    initial begin
        int n0, b0, s0, k;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_outputs",
              {19'd0, fifo_read_enb, soft_reset, vld_out, sop, eop, parity_err, data_out}, 0);
        @(posedge clock);
        #1 resetn = 1'b1;
        dst_mode = 0;
        repeat (2) @(posedge clock);

        // T1: hdr 0x0D, payload 11 22 33, parity 0x0D
        n0 = beat_time.size();
        b0 = beat_cnt;
        send_pkt(6'd3, 2'd1, 8'h11, 1'b0);
        wait_drain("t1_drain", 100);
        check("t1_beats", beat_cnt - b0, 5);
        check("t1_stream", beat_time[n0 + 4] - beat_time[n0 + 1], 3);
        check("t1_hdr_gap", 32'(beat_time[n0 + 1] - beat_time[n0] <= 2), 1);
        check("t1_perr", parity_err, 0);
        check("t1_idle_vld", vld_out, 0);

        // T2: corrupted parity 0x0E
        b0 = beat_cnt;
        send_pkt(6'd3, 2'd1, 8'h11, 1'b1);
        wait_drain("t2_drain", 100);
        check("t2_beats", beat_cnt - b0, 5);
        check("t2_perr", parity_err, PerrExp);
        repeat (5) @(posedge clock);
        check("t2_perr_held", parity_err, PerrExp);

        // T3: zero-length packet, hdr 0x02
        b0 = beat_cnt;
        send_pkt(6'd0, 2'd2, 8'h00, 1'b0);
        wait_drain("t3_drain", 100);
        check("t3_beats", beat_cnt - b0, 2);
        check("t3_perr_cleared", parity_err, 0);

        // T4: stall after three beats until timeout flush
        b0 = beat_cnt;
        s0 = sr_cycles;
        send_pkt(6'd10, 2'd3, 8'h40, 1'b0);
        wait_beats(b0 + 3);
        dst_mode = 2;
        k = 0;
        while (sr_cycles == s0 && k < 200) begin
            @(posedge clock);
            k++;
        end
        repeat (4) @(posedge clock);
        check("t4_sr_width", sr_cycles - s0, 1);
        check("t4_stall_len", sr_stall, 30);
        check("t4_sr_vld", sr_vld_bad, 0);
        check("t4_beats", beat_cnt - b0, 3);
        check("t4_vld_after", vld_out, 0);
        exp_q.delete();
        dst_mode = 0;
        repeat (3) @(posedge clock);

        // T5: random destination back-pressure, len 20
        dst_mode = 1;
        b0 = beat_cnt;
        send_pkt(6'd20, 2'd0, 8'h05, 1'b0);
        wait_drain("t5_drain", 500);
        check("t5_beats", beat_cnt - b0, 22);
        dst_mode = 0;
        check("t5_rd_empty", rd_viol, 0);
        repeat (2) @(posedge clock);

        // T6: reset after the third beat, then a clean packet
        b0 = beat_cnt;
        send_pkt(6'd10, 2'd2, 8'h80, 1'b0);
        wait_beats(b0 + 3);
        #1 resetn = 1'b0;
        @(posedge clock);
        #2;
        fifo_q.delete();
        fifo_empty = 1'b1;
        exp_q.delete();
        @(negedge clock);
        check("t6_reset_outputs",
              {19'd0, fifo_read_enb, soft_reset, vld_out, sop, eop, parity_err, data_out}, 0);
        @(posedge clock);
        #1 resetn = 1'b1;
        repeat (2) @(posedge clock);
        b0 = beat_cnt;
        send_pkt(6'd3, 2'd1, 8'h11, 1'b0);
        wait_drain("t6_drain", 100);
        check("t6_beats", beat_cnt - b0, 5);
        check("t6_perr", parity_err, 0);
        check("final_rd_empty", rd_viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
